// File: rtl/hdl_rec_pkg.sv
// Shared types and constants for the sample recorder.
package hdl_rec_pkg;

  // ARMED keeps its encoding even when the trigger feature is compiled out.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_t;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Saturating increment for the error counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hdl_rec_mem.sv
// Capture memory: DEPTH x DATA_W, one synchronous write port and one registered
// read port. Reads return the pre-write contents on a same-index collision.
module hdl_rec_mem
  import hdl_rec_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read data holds its last value when no read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem[raddr_i];
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hdl_sample_recorder.sv
// Captures DEPTH consecutive valid samples, counts non-increment steps and
// exposes the captured values through a registered read port.
// Optional start trigger: define HDL_REC_TRIGGER_EN.
module hdl_sample_recorder
  import hdl_rec_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] value_i,
`ifdef HDL_REC_TRIGGER_EN
  input  logic [DATA_W-1:0] trig_val_i,
`endif
  input  logic              rd_req_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        err_cnt_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  wptr, wptr_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              first_q, first_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] prev_inc;

  // Expected next sample, wrapping at DATA_W bits.
  assign prev_inc = prev_q + DATA_W'(1);

  // Capture FSM, write pointer and increment checker next-state.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr;
    prev_d    = prev_q;
    first_d   = first_q;
    err_cnt_d = err_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wptr;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm_i) begin
`ifdef HDL_REC_TRIGGER_EN
          state_d = StArmed;
`else
          state_d = StCapture;
`endif
          wptr_d    = '0;
          err_cnt_d = '0;
          first_d   = 1'b1;
        end
      end
      StArmed: begin
`ifdef HDL_REC_TRIGGER_EN
        // Trigger sample becomes entry 0; it has no predecessor to check.
        if (valid_i && (value_i == trig_val_i)) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wptr_d    = IDX_W'(1);
          prev_d    = value_i;
          first_d   = 1'b0;
          state_d   = StCapture;
        end
`else
        state_d = StIdle;
`endif
      end
      StCapture: begin
        if (valid_i) begin
          mem_we  = 1'b1;
          wptr_d  = wptr + IDX_W'(1);
          if (!first_q && (value_i != prev_inc)) err_cnt_d = sat_inc(err_cnt_q);
          prev_d  = value_i;
          first_d = 1'b0;
          if (wptr == LastIdx) state_d = StDone;
        end
      end
    endcase
  end

  // One-cycle read acknowledge.
  always_comb begin
    rd_valid_d = rd_req_i;
  end

  // State registers; mem is reset-free and lives in u_mem.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wptr       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      err_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr       <= wptr_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      err_cnt_q  <= err_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // A sample arriving with reset is discarded.
  hdl_rec_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mem_we && !rst),
    .waddr_i(mem_waddr),
    .wdata_i(value_i),
    .re_i   (rd_req_i),
    .raddr_i(rd_idx_i),
    .rdata_o(rd_data_o)
  );

  assign rd_valid_o = rd_valid_q;
  assign busy_o     = (state_q == StCapture) || (state_q == StArmed);
  assign done_o     = (state_q == StDone);
  assign err_cnt_o  = err_cnt_q;

endmodule
